// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//
// Shares one single-cycle ALU between two requesters. Each requester offers
// operands over a valid/ready handshake; the arbiter picks one, registers its
// operands into the ALU, captures the ALU result one cycle later into that
// port's response register, then holds the response until it is consumed.
// Ties go round-robin: the port that was not served last wins.
//
// Sequence per operation: IDLE (accept) -> EXEC (ALU settles) -> RESP (hold
// until consumed) -> IDLE, giving at most one operation every three clocks.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   req{0,1}_valid/_ready       request handshake (ready is combinational,
//                               only in IDLE, never both ports at once)
//   req{0,1}_a/_b/_op           request operands and ALU code
//   rsp{0,1}_valid/_ready       response handshake
//   rsp{0,1}_result/_zero       captured ALU result and zero flag
//   alu_a/alu_b/alu_control     registered operands to the ALU; they keep the
//                               last granted values while idle
//   alu_result/alu_zero         ALU outputs
//   gnt{0,1}_cnt                per-port grant counters (only when
//                               ALU_ARB_PERF_EN is defined; wrap at 2^CNT_W)
//
// Build option: define ALU_ARB_PERF_EN to add the grant counters.
// ---------------------------------------------------------------------------
module alu_arbiter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [3:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [3:0]       req1_op,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_result,
    output logic             rsp0_zero,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_result,
    output logic             rsp1_zero,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_control,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero
`ifdef ALU_ARB_PERF_EN
    ,
    output logic [CNT_W-1:0] gnt0_cnt,
    output logic [CNT_W-1:0] gnt1_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    logic   last_gnt;   // port served most recently; the other wins a tie
    logic   gnt_id;     // port currently being served
    logic   grant0;
    logic   grant1;

    // Arbitration: a lone valid port wins outright; on a tie the port that
    // was not served last wins, so the two grants are mutually exclusive.
    assign grant0 = (state == IDLE) && req0_valid && (!req1_valid || last_gnt);
    assign grant1 = (state == IDLE) && req1_valid && (!req0_valid || !last_gnt);

    // Ready is forced low while reset is asserted so nothing looks accepted.
    assign req0_ready = rst_n && grant0;
    assign req1_ready = rst_n && grant1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            last_gnt    <= 1'b1;
            gnt_id      <= 1'b0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_control <= '0;
            rsp0_valid  <= 1'b0;
            rsp0_result <= '0;
            rsp0_zero   <= 1'b0;
            rsp1_valid  <= 1'b0;
            rsp1_result <= '0;
            rsp1_zero   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant0) begin
                        alu_a       <= req0_a;
                        alu_b       <= req0_b;
                        alu_control <= req0_op;
                        gnt_id      <= 1'b0;
                        state       <= EXEC;
                    end else if (grant1) begin
                        alu_a       <= req1_a;
                        alu_b       <= req1_b;
                        alu_control <= req1_op;
                        gnt_id      <= 1'b1;
                        state       <= EXEC;
                    end
                end
                EXEC: begin
                    // The ALU has had a full cycle on the registered operands.
                    if (!gnt_id) begin
                        rsp0_result <= alu_result;
                        rsp0_zero   <= alu_zero;
                        rsp0_valid  <= 1'b1;
                    end else begin
                        rsp1_result <= alu_result;
                        rsp1_zero   <= alu_zero;
                        rsp1_valid  <= 1'b1;
                    end
                    state <= RESP;
                end
                RESP: begin
                    if (!gnt_id && rsp0_ready) begin
                        rsp0_valid <= 1'b0;
                        last_gnt   <= 1'b0;
                        state      <= IDLE;
                    end else if (gnt_id && rsp1_ready) begin
                        rsp1_valid <= 1'b0;
                        last_gnt   <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ALU_ARB_PERF_EN
    // Grant counters advance on each accepted request and wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt0_cnt <= '0;
            gnt1_cnt <= '0;
        end else begin
            if (grant0) gnt0_cnt <= gnt0_cnt + 1'b1;
            if (grant1) gnt1_cnt <= gnt1_cnt + 1'b1;
        end
    end
`endif

    // Reject degenerate parameter overrides at elaboration.
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("alu_arbiter: CNT_W must be at least 1");
    end
    if (WIDTH < 1) begin : g_bad_width
        $error("alu_arbiter: WIDTH must be at least 1");
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_arbiter
//
// Drives alu_arbiter with a behavioural ALU attached. A fixed vector table
// covers the named scenarios (single add, round-robin ties, back-pressure,
// unknown op code, wrap-around add); hand sequences cover reset behaviour;
// a randomized loop is checked against a reference model that tracks the
// round-robin owner and computes results arithmetically.
// ---------------------------------------------------------------------------
module tb_alu_arbiter;

    localparam int WIDTH    = 32;
    localparam int TB_CNT_W = 4;

    logic             clk;
    logic             rst_n;
    logic             req0_valid, req1_valid;
    logic             req0_ready, req1_ready;
    logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]       req0_op, req1_op;
    logic             rsp0_valid, rsp1_valid;
    logic             rsp0_ready, rsp1_ready;
    logic [WIDTH-1:0] rsp0_result, rsp1_result;
    logic             rsp0_zero, rsp1_zero;
    logic [WIDTH-1:0] alu_a, alu_b;
    logic [3:0]       alu_control;
    logic [WIDTH-1:0] alu_result;
    logic             alu_zero;
`ifdef ALU_ARB_PERF_EN
    logic [TB_CNT_W-1:0] gnt0_cnt, gnt1_cnt;
`endif

    alu_arbiter #(.WIDTH(WIDTH), .CNT_W(TB_CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp0_result(rsp0_result), .rsp0_zero(rsp0_zero),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero),
        .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
        .alu_result(alu_result), .alu_zero(alu_zero)
`ifdef ALU_ARB_PERF_EN
        , .gnt0_cnt(gnt0_cnt), .gnt1_cnt(gnt1_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural single-cycle ALU connected to the arbiter.
    always_comb begin
        alu_result = '0;
        case (alu_control)
            4'b0000: alu_result = alu_a + alu_b;
            4'b0001: alu_result = alu_a | alu_b;
            4'b0010: alu_result = alu_a & alu_b;
            4'b0011: alu_result = alu_a << alu_b[4:0];
            default: alu_result = '0;
        endcase
        alu_zero = (alu_result == '0);
    end

    int checks   = 0;
    int failures = 0;
    int model_last = 1;   // port served most recently (reset: 1)
    int exp_cnt0 = 0;
    int exp_cnt1 = 0;

    typedef struct {
        logic        v0;
        logic        v1;
        logic [31:0] a0;
        logic [31:0] b0;
        logic [3:0]  op0;
        logic [31:0] a1;
        logic [31:0] b1;
        logic [3:0]  op1;
        int          port;
        logic [31:0] res;
        logic        zero;
        int          hold;
    } vec_t;

    vec_t tbl [7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference ALU from the operation definitions.
    function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] op);
        longint unsigned full;
        case (op)
            4'd0: full = longint'(a) + longint'(b);
            4'd1: full = longint'(a | b);
            4'd2: full = longint'(a & b);
            4'd3: full = longint'(a) * (64'd1 << (b % 32));
            default: full = 0;
        endcase
        return full[31:0];
    endfunction

    // One full transaction: offer, accept, EXEC, RESP (optionally held), consume.
    task automatic run_txn(input vec_t t, input string tag);
        logic [31:0] wa, wb, held;
        logic [3:0]  wop;
        wa  = (t.port == 0) ? t.a0 : t.a1;
        wb  = (t.port == 0) ? t.b0 : t.b1;
        wop = (t.port == 0) ? t.op0 : t.op1;
        req0_valid = t.v0; req0_a = t.a0; req0_b = t.b0; req0_op = t.op0;
        req1_valid = t.v1; req1_a = t.a1; req1_b = t.b1; req1_op = t.op1;
        rsp0_ready = (t.hold == 0);
        rsp1_ready = (t.hold == 0);
        #1;
        check({tag, ":req0_ready"}, req0_ready, t.port == 0);
        check({tag, ":req1_ready"}, req1_ready, t.port == 1);
        if (!req0_ready && !req1_ready) begin
            req0_valid = 1'b0;
            req1_valid = 1'b0;
            return;
        end
        @(posedge clk); @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check({tag, ":exec_rsp0_valid"}, rsp0_valid, 1'b0);
        check({tag, ":exec_rsp1_valid"}, rsp1_valid, 1'b0);
        check({tag, ":alu_a"}, alu_a, wa);
        check({tag, ":alu_b"}, alu_b, wb);
        check({tag, ":alu_control"}, alu_control, wop);
        @(posedge clk); @(negedge clk);
        check({tag, ":rsp_valid"}, (t.port == 0) ? rsp0_valid : rsp1_valid, 1'b1);
        check({tag, ":other_valid"}, (t.port == 0) ? rsp1_valid : rsp0_valid, 1'b0);
        check({tag, ":result"}, (t.port == 0) ? rsp0_result : rsp1_result, t.res);
        check({tag, ":zero"}, (t.port == 0) ? rsp0_zero : rsp1_zero, t.zero);
        held = (t.port == 0) ? rsp0_result : rsp1_result;
        for (int i = 0; i < t.hold; i++) begin
            req0_valid = 1'b1;
            req1_valid = 1'b1;
            @(posedge clk); @(negedge clk);
            check({tag, ":bp_ready"}, {req0_ready, req1_ready}, 2'b00);
            check({tag, ":bp_valid"}, (t.port == 0) ? rsp0_valid : rsp1_valid, 1'b1);
            check({tag, ":bp_result"}, (t.port == 0) ? rsp0_result : rsp1_result, held);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        check({tag, ":done_valid"}, {rsp0_valid, rsp1_valid}, 2'b00);
        check({tag, ":idle_alu_a"}, alu_a, wa);
        model_last = t.port;
        if (t.port == 0) exp_cnt0++; else exp_cnt1++;
        $display("txn %s port=%0d op=%0h a=%0h b=%0h result=%0h zero=%0b",
                 tag, t.port, wop, wa, wb, t.res, t.zero);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ":ready"}, {req0_ready, req1_ready}, 2'b00);
        check({tag, ":rsp_valid"}, {rsp0_valid, rsp1_valid}, 2'b00);
        check({tag, ":rsp_result"}, {rsp0_result, rsp1_result}, 64'd0);
        check({tag, ":rsp_zero"}, {rsp0_zero, rsp1_zero}, 2'b00);
        check({tag, ":alu_ab"}, {alu_a, alu_b}, 64'd0);
        check({tag, ":alu_control"}, alu_control, 4'd0);
`ifdef ALU_ARB_PERF_EN
        check({tag, ":cnt"}, {gnt0_cnt, gnt1_cnt}, 8'd0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t r;
        int sel;
        rst_n = 1'b0;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = '0;
        req1_valid = 1'b1; req1_a = '0; req1_b = '0; req1_op = '0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        #1;
        check_all_zero("reset");
        req1_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset while a transaction is in EXEC: everything clears, no response.
        req0_valid = 1'b1; req0_a = 32'd3; req0_b = 32'd4; req0_op = 4'd0;
        #1;
        check("t1:accept", req0_ready, 1'b1);
        @(posedge clk); @(negedge clk);
        req0_valid = 1'b0;
        check("t1:alu_a_loaded", alu_a, 32'd3);
        rst_n = 1'b0;
        #1;
        check_all_zero("t1");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t1:no_rsp", {rsp0_valid, rsp1_valid}, 2'b00);
        end
        $display("txn t1 reset mid-EXEC dropped");
        model_last = 1;

        // Directed vectors (expected port follows from reset tie-break onward).
        tbl[0] = '{1'b1, 1'b0, 32'd5, 32'd7, 4'd0, 32'd0, 32'd0, 4'd0, 0, 32'd12, 1'b0, 0};
        tbl[1] = '{1'b1, 1'b1, 32'hF0, 32'h0F, 4'd2, 32'd1, 32'd4, 4'd3, 1, 32'd16, 1'b0, 0};
        tbl[2] = '{1'b1, 1'b1, 32'hF0, 32'h0F, 4'd2, 32'd1, 32'd4, 4'd3, 0, 32'd0, 1'b1, 0};
        tbl[3] = '{1'b1, 1'b1, 32'd1, 32'd1, 4'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd7, 1, 32'd0, 1'b1, 0};
        tbl[4] = '{1'b0, 1'b1, 32'd0, 32'd0, 4'd0, 32'h0F0, 32'hF00, 4'd1, 1, 32'hFF0, 1'b0, 5};
        tbl[5] = '{1'b1, 1'b0, 32'hFFFFFFFF, 32'd1, 4'd0, 32'd0, 32'd0, 4'd0, 0, 32'd0, 1'b1, 0};
        tbl[6] = '{1'b1, 1'b1, 32'h12, 32'h21, 4'd1, 32'hFF00, 32'h0FF0, 4'd2, 1, 32'h0F00, 1'b0, 0};
        for (int i = 0; i < 7; i++) begin
            run_txn(tbl[i], $sformatf("vec%0d", i));
        end
`ifdef ALU_ARB_PERF_EN
        check("t6:gnt0_cnt", gnt0_cnt, 4'd3);
        check("t6:gnt1_cnt", gnt1_cnt, 4'd4);
`endif

        // Randomized traffic against the reference model.
        for (int i = 0; i < 48; i++) begin
            sel    = $urandom_range(1, 3);
            r.v0   = sel[0];
            r.v1   = sel[1];
            r.a0   = $urandom; r.b0 = $urandom;
            r.a1   = $urandom; r.b1 = $urandom;
            r.op0  = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
            r.op1  = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
            if (r.v0 && r.v1) r.port = (model_last == 1) ? 0 : 1;
            else              r.port = r.v0 ? 0 : 1;
            r.res  = (r.port == 0) ? ref_alu(r.a0, r.b0, r.op0) : ref_alu(r.a1, r.b1, r.op1);
            r.zero = (r.res == 32'd0);
            r.hold = $urandom_range(0, 3);
            run_txn(r, $sformatf("rnd%0d", i));
        end
`ifdef ALU_ARB_PERF_EN
        check("t6:gnt0_cnt_wrap", gnt0_cnt, 4'(exp_cnt0 % 16));
        check("t6:gnt1_cnt_wrap", gnt1_cnt, 4'(exp_cnt1 % 16));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
